// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit RISC core. Sequences the PC/IR/A/B/ALUOut/MDR
// register enables, register-file write, memory strobes and datapath selects, and bounds
// every memory wait with a timeout that parks the core in ERROR.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_latch,
  output logic             ir_latch,
  output logic             a_latch,
  output logic             b_latch,
  output logic             alu_latch,
  output logic             mdr_latch,
  output logic             rf_we,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             addr_sel,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             wb_sel,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_dbg
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StExec   = 4'd2;
  localparam logic [3:0] StWbAlu  = 4'd3;
  localparam logic [3:0] StAddr   = 4'd4;
  localparam logic [3:0] StMemRd  = 4'd5;
  localparam logic [3:0] StWbMem  = 4'd6;
  localparam logic [3:0] StMemWr  = 4'd7;
  localparam logic [3:0] StBranch = 4'd8;
  localparam logic [3:0] StJump   = 4'd9;
  localparam logic [3:0] StHalt   = 4'd10;
  localparam logic [3:0] StError  = 4'd11;

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              bus_err_q;
  logic              cnt_inc;

  logic is_r, is_addi, is_ld, is_st, is_beq, is_jmp, is_hlt, is_illegal;
  logic in_wait, wait_last;

  assign is_r       = ~opcode[3];
  assign is_addi    = (opcode == 4'b1000);
  assign is_ld      = (opcode == 4'b1001);
  assign is_st      = (opcode == 4'b1010);
  assign is_beq     = (opcode == 4'b1011);
  assign is_jmp     = (opcode == 4'b1100);
  assign is_hlt     = (opcode == 4'b1111);
  assign is_illegal = (opcode == 4'b1101) || (opcode == 4'b1110);

  assign in_wait   = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // The current not-ready cycle is the one that would bring the count up to the limit;
  // a mem_ready in that same cycle still completes the access.
  assign wait_last = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // Next-state decode and retire detection
  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_ready)      state_d = StDecode;
        else if (wait_last) state_d = StError;
      end
      StDecode: begin
        if (is_r || is_addi)    state_d = StExec;
        else if (is_ld || is_st) state_d = StAddr;
        else if (is_beq)        state_d = StBranch;
        else if (is_jmp)        state_d = StJump;
        else if (is_hlt)        state_d = StHalt;
        else                    state_d = StFetch;
      end
      StExec:  state_d = StWbAlu;
      StWbAlu: begin
        state_d = StFetch;
        cnt_inc = 1'b1;
      end
      StAddr:  state_d = is_st ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready)      state_d = StWbMem;
        else if (wait_last) state_d = StError;
      end
      StWbMem: begin
        state_d = StFetch;
        cnt_inc = 1'b1;
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
          cnt_inc = 1'b1;
        end else if (wait_last) begin
          state_d = StError;
        end
      end
      StBranch, StJump: begin
        state_d = StFetch;
        cnt_inc = 1'b1;
      end
      StHalt:  state_d = StHalt;
      StError: state_d = StError;
      default: state_d = StFetch;
    endcase
  end

  // Wait counter restarts on every state change, so each access gets a fresh budget
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)       wait_d = '0;
    else if (in_wait && !mem_ready) wait_d = wait_q + 1'b1;
  end

  // State, wait counter, retire counter and sticky bus error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (cnt_inc)            cnt_q     <= cnt_q + 1'b1;
      if (state_d == StError) bus_err_q <= 1'b1;
    end
  end

  // Control outputs; everything is forced low while reset is asserted
  always_comb begin
    pc_latch   = 1'b0;
    ir_latch   = 1'b0;
    a_latch    = 1'b0;
    b_latch    = 1'b0;
    alu_latch  = 1'b0;
    mdr_latch  = 1'b0;
    rf_we      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    pc_src     = 2'd0;
    alu_src    = 1'b0;
    alu_op     = 3'd0;
    wb_sel     = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_latch = 1'b1;
            pc_latch = 1'b1;
          end
        end
        StDecode: begin
          a_latch    = 1'b1;
          b_latch    = 1'b1;
          illegal_op = is_illegal;
        end
        StExec: begin
          alu_latch = 1'b1;
          alu_src   = is_addi;
          alu_op    = is_addi ? 3'd0 : opcode[2:0];
        end
        StWbAlu: rf_we = 1'b1;
        StAddr: begin
          alu_latch = 1'b1;
          alu_src   = 1'b1;
        end
        StMemRd: begin
          mem_rd    = 1'b1;
          addr_sel  = 1'b1;
          mdr_latch = mem_ready;
        end
        StWbMem: begin
          rf_we  = 1'b1;
          wb_sel = 1'b1;
        end
        StMemWr: begin
          mem_wr   = 1'b1;
          addr_sel = 1'b1;
        end
        StBranch: begin
          alu_op = 3'd1;
          if (zero) begin
            pc_latch = 1'b1;
            pc_src   = 2'd1;
          end
        end
        StJump: begin
          pc_latch = 1'b1;
          pc_src   = 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign halted      = rst_n && (state_q == StHalt);
  assign bus_err     = rst_n && bus_err_q;
  assign instr_count = rst_n ? cnt_q : '0;
  assign state_dbg   = rst_n ? state_q : StFetch;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the 16-bit RISC core. It sequences the datapath's enable-gated pipeline registers: PC, IR, A, B, ALUOut and MDR. It also drives register-file write, memory read/write strobes and datapath mux selects. A wait/timeout handshake with instruction/data memory sits between memory and the register latches.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory access waits for mem_ready before bus error.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
opcode  in  4  IR[15:12], valid from DECODE onward
zero  in  1  ALU zero flag (A−B), valid in BRANCH state
mem_ready  in  1  memory access complete this cycle
pc_latch  out  1  PC register enable
ir_latch  out  1  IR register enable
a_latch  out  1  A register enable
b_latch  out  1  B register enable
alu_latch  out  1  ALUOut register enable
mdr_latch  out  1  MDR register enable
rf_we  out  1  register-file write enable
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
addr_sel  out  1  memory address: 0=PC, 1=ALUOut
pc_src  out  2  0=PC+1, 1=branch target, 2=jump target
alu_src  out  1  ALU B operand: 0=B reg, 1=sign-ext imm
alu_op  out  3  ALU function
wb_sel  out  1  writeback: 0=ALUOut, 1=MDR
halted  out  1  core halted (level)
bus_err  out  1  sticky memory timeout flag
illegal_op  out  1  one-cycle pulse on undefined opcode
instr_count  out  CNT_W  retired-instruction count
state_dbg  out  4  current state encoding

Behaviour:
- Opcodes:
  - 0000–0111: R-type ALU, alu_op=opcode[2:0].
  - 1000: ADDI.
  - 1001: LD.
  - 1010: ST.
  - 1011: BEQ.
  - 1100: JMP.
  - 1111: HLT.
  - 1101 and 1110: illegal.
- States: FETCH(0), DECODE(1), EXEC(2), WB_ALU(3), ADDR(4), MEM_RD(5), WB_MEM(6), MEM_WR(7), BRANCH(8), JUMP(9), HALT(10), ERROR(11).
- Reset: state=FETCH, and every output is 0 on the same edge.
  - Covers all latch/strobe/select outputs, halted, bus_err, instr_count.
  - Reset mid-access abandons the access with no write strobe the next cycle.
- Default: every enable/strobe is 0 and every select is 0 unless listed below.
- FETCH:
  - mem_rd=1, addr_sel=0.
  - If mem_ready: ir_latch=1, pc_latch=1, pc_src=0, next DECODE.
  - Otherwise stay.
- DECODE: a_latch=b_latch=1. Next state by opcode:
  - R/ADDI → EXEC.
  - LD/ST → ADDR.
  - BEQ → BRANCH.
  - JMP → JUMP.
  - HLT → HALT.
  - Illegal → FETCH, with illegal_op=1 for this cycle and instr_count unchanged.
- EXEC: alu_latch=1; alu_src=1 for ADDI, else 0; alu_op=opcode[2:0] for R, 000 (add) for ADDI. Next WB_ALU.
- WB_ALU: rf_we=1, wb_sel=0; instr_count++; next FETCH.
- ADDR: alu_latch=1, alu_src=1, alu_op=000. Next MEM_RD if LD, MEM_WR if ST.
- MEM_RD:
  - mem_rd=1, addr_sel=1.
  - If mem_ready: mdr_latch=1, next WB_MEM.
- WB_MEM: rf_we=1, wb_sel=1; instr_count++; next FETCH.
- MEM_WR:
  - mem_wr=1, addr_sel=1.
  - If mem_ready: instr_count++, next FETCH.
- BRANCH:
  - alu_op=001 (sub).
  - If zero: pc_latch=1, pc_src=1.
  - instr_count++; next FETCH.
- JUMP: pc_latch=1, pc_src=2; instr_count++; next FETCH.
- HALT: halted=1, no enables; stays until reset. HLT itself is not counted.
- Memory timeout (wait states FETCH, MEM_RD, MEM_WR):
  - A wait counter clears on entry to each of these states and increments each cycle mem_ready=0.
  - If the count reaches MEM_TIMEOUT with mem_ready=0, the next state is ERROR and bus_err is set.
  - A mem_ready arriving in the same cycle as the limit wins: the access completes, no error.
- ERROR: all enables 0; bus_err=1; stays until reset.
- Output timing:
  - Enables in wait states are Mealy, qualified by mem_ready.
  - All other outputs are Moore.
- instr_count wraps from 2^CNT_W−1 to 0.
- Latency with mem_ready held 1: R/ADDI 4 cycles, LD 5, ST 4, BEQ 3, JMP 3.

Test Plan:
- ADD (opcode 0000), mem_ready=1 → states 0,1,2,3,0; ir/pc pulse cycle 1, a/b cycle 2, alu_latch with alu_op=000 cycle 3, rf_we with wb_sel=0 cycle 4; instr_count 0→1.
- LD with mem_ready low 3 cycles in MEM_RD → mem_rd/addr_sel=1 held 4 cycles, single mdr_latch pulse on the ready cycle, then rf_we with wb_sel=1; total 8 cycles.
- BEQ with zero=1, then BEQ with zero=0 → first gives pc_latch with pc_src=1 in BRANCH; second gives no pc_latch; instr_count +2.
- Opcode 1101 → illegal_op single pulse in DECODE, back to FETCH, instr_count unchanged; HLT → halted=1 held indefinitely, no strobes.
- mem_ready held 0 in FETCH → after MEM_TIMEOUT (15) wait cycles the state goes to ERROR(11) with bus_err=1; ready arriving exactly at cycle 15 → no error.
- Assert rst_n=0 during MEM_WR wait → next cycle mem_wr=0, state FETCH, bus_err=0, instr_count=0; instr_count preloaded near 16'hFFFF wraps to 0 after the retire.
